// File: rtl/latch_pkg.sv
// latch_pkg: shared types and helpers for the latch_queue capture queue.
`default_nettype none

package latch_pkg;

  typedef enum logic {
    LATCH_DROP_NEW         = 1'b0,
    LATCH_OVERWRITE_OLDEST = 1'b1
  } latch_ovf_mode_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/latch_queue_mem.sv
// latch_queue_mem: DEPTH x WIDTH register array, one write port, async read, no reset.
`default_nettype none

module latch_queue_mem
  import latch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/latch_queue.sv
// latch_queue: DEPTH-entry capture queue with occupancy, overflow policy and sticky overflow flag.
`default_nettype none

module latch_queue
  import latch_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter latch_ovf_mode_e OVF_MODE = LATCH_DROP_NEW
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       latch,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       out_ack,
  input  logic                       clr_ovf,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_vld,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             empty, is_full;
  logic             pop, push, ovf_evt, overwrite, wr_en;
  logic [WIDTH-1:0] rd_data;

  assign empty   = (level_q == '0);
  assign is_full = (level_q == LW'(DEPTH));

  // A pop in the same cycle frees the slot, so a full queue still accepts the word.
  assign pop       = out_ack && !empty;
  assign push      = latch && (!is_full || pop);
  assign ovf_evt   = latch && is_full && !pop;
  assign overwrite = ovf_evt && (OVF_MODE == LATCH_OVERWRITE_OLDEST);
  assign wr_en     = push || overwrite;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (wr_en) begin
      tail_d = tail_q + PW'(1);
    end
    if (pop || overwrite) begin
      head_d = head_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  latch_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (ap_clk),
    .we_i    (wr_en),
    .waddr_i (tail_q),
    .wdata_i (data_in),
    .raddr_i (head_q),
    .rdata_o (rd_data)
  );

  assign data_out = empty ? '0 : rd_data;
  assign out_vld  = !empty;
  assign full     = is_full;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_queue.sv
// tb_latch_queue: table-driven check of latch_queue in both overflow modes with shared stimulus.
`default_nettype none

module tb_latch_queue;
  import latch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        latch_s = 1'b0;
  logic [31:0] din = '0;
  logic        ack = 1'b0;
  logic        clr = 1'b0;

  logic [31:0] dout_d, dout_o;
  logic        vld_d, vld_o, full_d, full_o, ovf_d, ovf_o;
  logic [2:0]  lvl_d, lvl_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  latch_queue #(.WIDTH(32), .DEPTH(4), .OVF_MODE(LATCH_DROP_NEW)) dut_drop (
    .ap_clk(clk), .ap_rst_n(rst_n), .latch(latch_s), .data_in(din), .out_ack(ack),
    .clr_ovf(clr), .data_out(dout_d), .out_vld(vld_d), .full(full_d), .level(lvl_d),
    .overflow(ovf_d)
  );

  latch_queue #(.WIDTH(32), .DEPTH(4), .OVF_MODE(LATCH_OVERWRITE_OLDEST)) dut_ow (
    .ap_clk(clk), .ap_rst_n(rst_n), .latch(latch_s), .data_in(din), .out_ack(ack),
    .clr_ovf(clr), .data_out(dout_o), .out_vld(vld_o), .full(full_o), .level(lvl_o),
    .overflow(ovf_o)
  );

  typedef struct {
    bit          l;
    logic [31:0] d;
    bit          a;
    bit          c;
    int          lvl;
    bit          vld;
    bit          fu;
    bit          ov;
    logic [31:0] dd;
    logic [31:0] dow;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit l, logic [31:0] d, bit a, bit c, int lvl, bit vld,
                              bit fu, bit ov, logic [31:0] dd, logic [31:0] dow);
    vec_t v;
    v.l = l; v.d = d; v.a = a; v.c = c; v.lvl = lvl; v.vld = vld;
    v.fu = fu; v.ov = ov; v.dd = dd; v.dow = dow;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic chk_all(input string tag, input int lvl, input bit vld, input bit fu,
                         input bit ov, input logic [31:0] dd, input logic [31:0] dow);
    chk({tag, " drop.level"},    32'(lvl_d),  32'(lvl));
    chk({tag, " drop.out_vld"},  32'(vld_d),  32'(vld));
    chk({tag, " drop.full"},     32'(full_d), 32'(fu));
    chk({tag, " drop.overflow"}, 32'(ovf_d),  32'(ov));
    chk({tag, " drop.data_out"}, dout_d,      dd);
    chk({tag, " ow.level"},      32'(lvl_o),  32'(lvl));
    chk({tag, " ow.out_vld"},    32'(vld_o),  32'(vld));
    chk({tag, " ow.full"},       32'(full_o), 32'(fu));
    chk({tag, " ow.overflow"},   32'(ovf_o),  32'(ov));
    chk({tag, " ow.data_out"},   dout_o,      dow);
  endtask

  initial begin
    // latch, data, ack, clr | level, vld, full, ovf, dout(drop), dout(overwrite)
    vecs.push_back(mk(1, 32'hA5A5_0001, 0, 0, 1, 1, 0, 0, 32'hA5A5_0001, 32'hA5A5_0001));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 2, 0, 0, 2, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 3, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4, 0, 0, 4, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 5, 0, 0, 4, 1, 1, 1, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0, 1, 2, 3));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 0, 1, 3, 4));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 1, 4, 5));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 2, 0, 0, 2, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 3, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4, 0, 0, 4, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 9, 1, 0, 4, 1, 1, 0, 2, 2));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, 4, 4));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 9, 9));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 0, 1, 1, 0, 0, 7, 7));
    vecs.push_back(mk(1, 32'h21, 0, 0, 2, 1, 0, 0, 7, 7));
    vecs.push_back(mk(1, 32'h22, 0, 0, 3, 1, 0, 0, 7, 7));
    vecs.push_back(mk(1, 32'h23, 0, 0, 4, 1, 1, 0, 7, 7));
    vecs.push_back(mk(1, 32'h24, 1, 1, 4, 1, 1, 0, 32'h21, 32'h21));
    vecs.push_back(mk(1, 32'h25, 0, 1, 4, 1, 1, 1, 32'h21, 32'h22));

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      latch_s = vecs[i].l;
      din     = vecs[i].d;
      ack     = vecs[i].a;
      clr     = vecs[i].c;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].vld, vecs[i].fu,
              vecs[i].ov, vecs[i].dd, vecs[i].dow);
    end

    // Reset pulse between edges with a full, overflowed queue: outputs clear at once.
    @(negedge clk);
    latch_s = 1'b0;
    ack     = 1'b0;
    clr     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_all("midreset", 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    latch_s = 1'b1;
    din     = 32'h11;
    @(posedge clk);
    #1;
    chk_all("postreset", 1, 1, 0, 0, 32'h11, 32'h11);
    @(negedge clk);
    latch_s = 1'b0;
    ack     = 1'b1;
    @(posedge clk);
    #1;
    chk_all("postreset_drain", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    ack = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
